// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan code decoder: folds E0/F0/E1 prefixes into key events and
// queues them in a first-word fall-through FIFO with overflow and error tracking.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int PREFIX_TIMEOUT = 1000000
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       CODE_VALID,
  input  logic [7:0] CODE,
  input  logic       CODE_ERR,
  input  logic       EV_READY,
  input  logic       CLR_OVF,
  output logic       EV_VALID,
  output logic [7:0] EV_CODE,
  output logic       EV_EXT,
  output logic       EV_BREAK,
  output logic       OVERFLOW,
  output logic [7:0] ERR_CNT
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = (PREFIX_TIMEOUT > 1) ? $clog2(PREFIX_TIMEOUT + 1) : 1;
  localparam int EV_W  = 10;

  localparam logic [7:0] B_E0 = 8'hE0;
  localparam logic [7:0] B_F0 = 8'hF0;
  localparam logic [7:0] B_E1 = 8'hE1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_E0,
    S_F0,
    S_E0F0,
    S_PAUSE
  } state_t;

  state_t            state;
  state_t            nxt_state;
  logic [2:0]        pause_cnt;
  logic [TO_W-1:0]   tmo_cnt;
  logic [7:0]        err_cnt;

  logic              dec_emit_p0;
  logic              dec_ext_p0;
  logic              dec_brk_p0;
  logic              vld_p0;

  logic [EV_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              ovf;
  logic              full;
  logic              pop;
  logic              wr_en;
  logic              drop;
  logic [EV_W-1:0]   head;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == B_E0) || (b == B_F0) || (b == B_E1);
  endfunction

  // Stage p0: decode the incoming byte against the current prefix state
  always_comb begin
    nxt_state   = state;
    dec_emit_p0 = 1'b0;
    dec_ext_p0  = 1'b0;
    dec_brk_p0  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (CODE == B_E0)      nxt_state = S_E0;
        else if (CODE == B_F0) nxt_state = S_F0;
        else if (CODE == B_E1) nxt_state = S_PAUSE;
        else                   dec_emit_p0 = 1'b1;
      end
      S_E0: begin
        if (CODE == B_F0)      nxt_state = S_E0F0;
        else if (CODE == B_E0) nxt_state = S_E0;
        else if (CODE == B_E1) nxt_state = S_PAUSE;
        else begin
          nxt_state   = S_IDLE;
          dec_emit_p0 = 1'b1;
          dec_ext_p0  = 1'b1;
        end
      end
      S_F0: begin
        nxt_state   = S_IDLE;
        dec_emit_p0 = !is_prefix(CODE);
        dec_brk_p0  = 1'b1;
      end
      S_E0F0: begin
        nxt_state   = S_IDLE;
        dec_emit_p0 = !is_prefix(CODE);
        dec_ext_p0  = 1'b1;
        dec_brk_p0  = 1'b1;
      end
      S_PAUSE: begin
        // E1 is followed by exactly seven payload bytes; the seventh ends it
        nxt_state = (pause_cnt == 3'd6) ? S_IDLE : S_PAUSE;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  assign vld_p0 = CODE_VALID && !CODE_ERR && dec_emit_p0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= S_IDLE;
      pause_cnt <= 3'd0;
      tmo_cnt   <= '0;
      err_cnt   <= 8'd0;
    end else if (CODE_VALID && CODE_ERR) begin
      state     <= S_IDLE;
      pause_cnt <= 3'd0;
      tmo_cnt   <= '0;
      err_cnt   <= sat_inc8(err_cnt);
    end else if (CODE_VALID) begin
      state     <= nxt_state;
      tmo_cnt   <= '0;
      pause_cnt <= (state == S_PAUSE && nxt_state == S_PAUSE) ? pause_cnt + 3'd1 : 3'd0;
    end else if (state != S_IDLE) begin
      if (tmo_cnt == TO_W'(PREFIX_TIMEOUT - 1)) begin
        state     <= S_IDLE;
        pause_cnt <= 3'd0;
        tmo_cnt   <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Stage p1: event FIFO; a pop frees the slot a same-cycle push needs when full
  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign pop   = EV_VALID && EV_READY;
  assign wr_en = vld_p0 && (!full || pop);
  assign drop  = vld_p0 && full && !pop;

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_ptr] <= {dec_ext_p0, dec_brk_p0, CODE};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      ovf <= (ovf && !CLR_OVF) || drop;
    end
  end

  assign head     = mem[rd_ptr];
  assign EV_VALID = (count != '0);
  assign EV_CODE  = EV_VALID ? head[7:0] : 8'd0;
  assign EV_BREAK = EV_VALID && head[8];
  assign EV_EXT   = EV_VALID && head[9];
  assign OVERFLOW = ovf;
  assign ERR_CNT  = err_cnt;

endmodule
